assert_gate_monitor: RTL and testbench
======================================

Name: assert_gate_monitor

Overview:
- Synthesizable, parametrised monitor for NUM_CH boolean check channels.
- Each channel's check is qualified by global arm/disarm control, a post-reset holdoff window and a per-channel enable mask.
- Per-channel outcomes are accumulated as saturating pass/fail counts, sticky fail flags and a first-failure record with a cycle timestamp.
- Sits beside datapath blocks as an in-silicon check aggregator and is readable by the debug/status path.

Parameters:
- NUM_CH, 4: number of independent check channels (1..32).
- HOLDOFF_CYCLES, 8: cycles after reset during which checks are ignored (0 = arm immediately).
- CNT_W, 16: width of each pass/fail counter.
- TS_W, 32: width of the free-running cycle timestamp.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- check_valid  in  NUM_CH  channel i has a check result this cycle.
- check_ok  in  NUM_CH  result of the check: 1 = pass, 0 = fail; sampled only when check_valid[i]=1.
- ch_en_mask  in  NUM_CH  per-channel enable; 0 = the channel's checks are ignored.
- assert_on  in  1  pulse: arm checking.
- assert_off  in  1  pulse: disarm checking.
- clr  in  1  pulse: clear all statistics.
- armed  out  1  state is ARMED.
- pass_cnt  out  NUM_CH*CNT_W  per-channel pass counts; channel i occupies bits [i*CNT_W +: CNT_W].
- fail_cnt  out  NUM_CH*CNT_W  per-channel fail counts; same packing as pass_cnt.
- fail_sticky  out  NUM_CH  set on the channel's first counted fail.
- first_fail_valid  out  1  first_fail_ch and first_fail_ts hold a record.
- first_fail_ch  out  $clog2(NUM_CH) (min 1)  channel index of the first counted fail.
- first_fail_ts  out  TS_W  timestamp of the first counted fail.

Behaviour:
- Reset: state=HOLDOFF (or ARMED if HOLDOFF_CYCLES=0), holdoff counter=0, timestamp=0; all outputs 0.
- States and transitions:
  - HOLDOFF: counts one per cycle; moves to ARMED after HOLDOFF_CYCLES cycles. assert_on during HOLDOFF moves to ARMED next cycle, ending the holdoff early.
  - ARMED: checks are evaluated.
  - OFF: checks are ignored.
  - assert_off in any state moves to OFF next cycle.
  - assert_on in OFF moves to ARMED next cycle, with no holdoff.
  - assert_on and assert_off in the same cycle: off wins.
- Counted check: channel i is counted in a cycle only when all hold: the registered state is ARMED that cycle, ch_en_mask[i]=1 and check_valid[i]=1. A control pulse therefore affects checks only from the following cycle.
- Latency: a counted pass or fail updates pass_cnt, fail_cnt, fail_sticky and the first_fail_* outputs on the next clock edge (1-cycle latency).
- Counters saturate at 2^CNT_W-1 and never wrap.
- Timestamp: free-running, wraps modulo 2^TS_W, counts in every state.
- first_fail record:
  - Captured only while first_fail_valid=0.
  - Simultaneous fails on several channels: the lowest index wins.
  - first_fail_ts is the timestamp value in the cycle the failing check was sampled.
- clr:
  - Zeroes counters, fail_sticky and the first_fail_* outputs next cycle.
  - Does not change state, holdoff progress or the timestamp.
  - Checks arriving in the same cycle as clr are discarded (clr wins).
- Reset asserted mid-operation: all statistics and state are lost and the holdoff restarts.
- ch_en_mask changes take effect in the same cycle they are sampled (no registering).

Optional Feature:
- ASSERT_GATE_PASS_CNT_EN defined: per-channel pass counters are implemented as described.
- Not defined:
  - No pass-counter storage is built; pass_cnt is driven constant 0.
  - Fail counting, sticky flags and the first-failure record are unchanged.

Decomposition:
- Package assert_gate_pkg holds:
  - state enum (HOLDOFF, ARMED, OFF);
  - function for the ch-index width, giving max(1, $clog2(NUM_CH));
  - saturating-increment function.
- One sub-module assert_gate_sat_cnt: CNT_W-bit saturating counter with synchronous clear and increment enable. It is instantiated 2*NUM_CH times (NUM_CH when the macro is off).

Test Plan:
- Holdoff:
  - Stimulus: rst released; check_valid=4'hF, check_ok=4'h0 on every cycle; ch_en_mask=4'hF.
  - Response: no counts for cycles 0..7; armed=1 after 8 cycles; each fail_cnt increments by 1 per cycle thereafter.
  - Response: first_fail_ch=0 and first_fail_ts=8; fail_sticky=4'hF.
- Off/on window:
  - Stimulus: when ARMED, pulse assert_off; drive fails on channel 2 for 50 cycles; then pulse assert_on; drive one pass on channel 2.
  - Response: fail_cnt[2] stays 0 for the 50 cycles; pass_cnt[2]=1; armed rises the cycle after assert_on.
- Simultaneous controls:
  - Stimulus: assert_on and assert_off in the same cycle while ARMED.
  - Response: state=OFF next cycle; armed=0.
- Mask and first-failure priority:
  - Stimulus: ch_en_mask=4'b1010; fail on channels 0,1,3 in the same cycle.
  - Response: channel 0 is ignored; first_fail_ch=1; fail_sticky=4'b1010.
- Saturation and clear:
  - Stimulus: CNT_W=4; channel 0 fails 20 times.
  - Response: fail_cnt[0]=15 and holds at 15.
  - Stimulus: pulse clr together with a fail on channel 0.
  - Response: all counters, fail_sticky and first_fail_valid are 0 next cycle.
- Macro off:
  - Stimulus: build without ASSERT_GATE_PASS_CNT_EN; drive 10 passes on channel 1.
  - Response: pass_cnt=0; fail path behaves identically to the macro-on build.

Source files
------------

// File: rtl/assert_gate_pkg.sv
// Shared types and helpers for the assertion gate monitor.
package assert_gate_pkg;

  // Gate state: HOLDOFF after reset, ARMED while checks count, OFF when disarmed.
  typedef enum logic [1:0] {
    HOLDOFF = 2'd0,
    ARMED   = 2'd1,
    OFF     = 2'd2
  } gate_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Increment that sticks at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/assert_gate_sat_cnt.sv
// CNT_W-bit saturating counter with synchronous clear and increment enable.
module assert_gate_sat_cnt
  import assert_gate_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority over increment; increment holds at the all-ones value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/assert_gate_monitor.sv
// Aggregates per-channel boolean checks into pass/fail counts, sticky fail
// flags and a first-failure record, gated by arm/disarm control and a
// post-reset holdoff. Optional macro ASSERT_GATE_PASS_CNT_EN builds the pass
// counters; without it pass_cnt reads as zero.
module assert_gate_monitor
  import assert_gate_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int CNT_W          = 16,
  parameter int TS_W           = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           check_valid,
  input  logic [NUM_CH-1:0]           check_ok,
  input  logic [NUM_CH-1:0]           ch_en_mask,
  input  logic                        assert_on,
  input  logic                        assert_off,
  input  logic                        clr,
  output logic                        armed,
  output logic [NUM_CH*CNT_W-1:0]     pass_cnt,
  output logic [NUM_CH*CNT_W-1:0]     fail_cnt,
  output logic [NUM_CH-1:0]           fail_sticky,
  output logic                        first_fail_valid,
  output logic [ch_idx_w(NUM_CH)-1:0] first_fail_ch,
  output logic [TS_W-1:0]             first_fail_ts
);

  localparam int CH_W = ch_idx_w(NUM_CH);
  localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HO_W-1:0] HO_LAST = HO_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

  gate_state_e       state_q, state_d;
  logic [HO_W-1:0]   ho_q, ho_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic              ffv_q, ffv_d;
  logic [CH_W-1:0]   ffch_q, ffch_d;
  logic [TS_W-1:0]   ffts_q, ffts_d;
  logic [NUM_CH-1:0] counted;
  logic [NUM_CH-1:0] fail_hit;

  // Next state: holdoff expiry, then assert_on, with assert_off overriding both.
  always_comb begin
    state_d = state_q;
    ho_d    = ho_q;
    ts_d    = ts_q + TS_W'(1);
    if (state_q == HOLDOFF) begin
      if (ho_q == HO_LAST) begin
        state_d = ARMED;
      end else begin
        ho_d = ho_q + HO_W'(1);
      end
    end
    if (assert_on && (state_q != ARMED)) begin
      state_d = ARMED;
    end
    if (assert_off) begin
      state_d = OFF;
    end
  end

  // A check counts only from the registered ARMED state, unmasked, and not under clr.
  always_comb begin
    counted = '0;
    if ((state_q == ARMED) && !clr) begin
      counted = check_valid & ch_en_mask;
    end
    fail_hit = counted & ~check_ok;
  end

  // Sticky flags and first-failure capture; the lowest failing channel wins a tie.
  always_comb begin
    sticky_d = sticky_q | fail_hit;
    ffv_d    = ffv_q;
    ffch_d   = ffch_q;
    ffts_d   = ffts_q;
    if (clr) begin
      sticky_d = '0;
      ffv_d    = 1'b0;
      ffch_d   = '0;
      ffts_d   = '0;
    end else if (!ffv_q && (|fail_hit)) begin
      ffv_d  = 1'b1;
      ffts_d = ts_q;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (fail_hit[i]) begin
          ffch_d = CH_W'(i);
        end
      end
    end
  end

  // Control and record registers; reset restarts the holdoff window.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (HOLDOFF_CYCLES == 0) begin
        state_q <= ARMED;
      end else begin
        state_q <= HOLDOFF;
      end
      ho_q     <= '0;
      ts_q     <= '0;
      sticky_q <= '0;
      ffv_q    <= 1'b0;
      ffch_q   <= '0;
      ffts_q   <= '0;
    end else begin
      state_q  <= state_d;
      ho_q     <= ho_d;
      ts_q     <= ts_d;
      sticky_q <= sticky_d;
      ffv_q    <= ffv_d;
      ffch_q   <= ffch_d;
      ffts_q   <= ffts_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_fail
    assert_gate_sat_cnt #(.CNT_W(CNT_W)) u_fail_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (fail_hit[i]),
      .cnt (fail_cnt[i*CNT_W +: CNT_W])
    );
  end

`ifdef ASSERT_GATE_PASS_CNT_EN
  logic [NUM_CH-1:0] pass_hit;
  assign pass_hit = counted & check_ok;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_pass
    assert_gate_sat_cnt #(.CNT_W(CNT_W)) u_pass_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .inc (pass_hit[i]),
      .cnt (pass_cnt[i*CNT_W +: CNT_W])
    );
  end
`else
  assign pass_cnt = '0;
`endif

  assign armed            = (state_q == ARMED);
  assign fail_sticky      = sticky_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_ch    = ffch_q;
  assign first_fail_ts    = ffts_q;

endmodule

// File: tb/tb_assert_gate_monitor.sv
// Scoreboard bench for assert_gate_monitor: a behavioural model predicts the
// outputs after every clock edge and a monitor compares them one cycle later.
module tb_assert_gate_monitor;

  localparam int NCH  = 4;
  localparam int HOLD = 8;
  localparam int CW   = 4;
  localparam int TSW  = 32;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ASSERT_GATE_PASS_CNT_EN
  localparam bit PASS_EN = 1'b1;
`else
  localparam bit PASS_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    check_valid;
  logic [NCH-1:0]    check_ok;
  logic [NCH-1:0]    ch_en_mask;
  logic              assert_on;
  logic              assert_off;
  logic              clr;
  logic              armed;
  logic [NCH*CW-1:0] pass_cnt;
  logic [NCH*CW-1:0] fail_cnt;
  logic [NCH-1:0]    fail_sticky;
  logic              first_fail_valid;
  logic [1:0]        first_fail_ch;
  logic [TSW-1:0]    first_fail_ts;

  assert_gate_monitor #(
    .NUM_CH(NCH), .HOLDOFF_CYCLES(HOLD), .CNT_W(CW), .TS_W(TSW)
  ) dut (
    .clk(clk), .rst(rst), .check_valid(check_valid), .check_ok(check_ok),
    .ch_en_mask(ch_en_mask), .assert_on(assert_on), .assert_off(assert_off),
    .clr(clr), .armed(armed), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .fail_sticky(fail_sticky), .first_fail_valid(first_fail_valid),
    .first_fail_ch(first_fail_ch), .first_fail_ts(first_fail_ts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              armed;
    logic [NCH*CW-1:0] pass;
    logic [NCH*CW-1:0] fail;
    logic [NCH-1:0]    sticky;
    logic              ffv;
    logic [1:0]        ffch;
    logic [TSW-1:0]    ffts;
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int errors = 0;

  // Reference model state, expressed as plain integers.
  int  hold_left;
  bit  disarmed;
  int  pass_m[NCH];
  int  fail_m[NCH];
  bit  sticky_m[NCH];
  bit  ffv_m;
  int  ffch_m;
  longint ts_m;
  longint ffts_m;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic clearStats();
    for (int i = 0; i < NCH; i++) begin
      pass_m[i] = 0;
      fail_m[i] = 0;
      sticky_m[i] = 1'b0;
    end
    ffv_m = 1'b0;
    ffch_m = 0;
    ffts_m = 0;
  endtask

  // Advance the model over one clock edge and return the outputs it predicts.
  task automatic modelStep(input logic [NCH-1:0] v, input logic [NCH-1:0] ok, input logic [NCH-1:0] m,
                           input bit on, input bit off, input bit c, input bit r, output exp_t e);
    if (r) begin
      clearStats();
      hold_left = HOLD;
      disarmed = 1'b0;
      ts_m = 0;
    end else begin
      if (c) begin
        clearStats();
      end else if (!disarmed && hold_left == 0) begin
        for (int i = 0; i < NCH; i++) begin
          if (v[i] && m[i]) begin
            if (ok[i]) begin
              if (pass_m[i] < CMAX) pass_m[i]++;
            end else begin
              if (fail_m[i] < CMAX) fail_m[i]++;
              sticky_m[i] = 1'b1;
              if (!ffv_m) begin
                ffv_m = 1'b1;
                ffch_m = i;
                ffts_m = ts_m;
              end
            end
          end
        end
      end
      if (off) begin
        disarmed = 1'b1;
      end else if (on) begin
        disarmed = 1'b0;
        hold_left = 0;
      end else if (hold_left > 0) begin
        hold_left--;
      end
      ts_m = (ts_m + 1) % (64'd1 << TSW);
    end
    e.armed = !disarmed && hold_left == 0;
    for (int i = 0; i < NCH; i++) begin
      e.pass[i*CW +: CW] = PASS_EN ? CW'(pass_m[i]) : '0;
      e.fail[i*CW +: CW] = CW'(fail_m[i]);
      e.sticky[i] = sticky_m[i];
    end
    e.ffv  = ffv_m;
    e.ffch = 2'(ffch_m);
    e.ffts = TSW'(ffts_m);
  endtask

  // Drive one cycle of inputs and queue the predicted response.
  task automatic applyStimulus(input logic [NCH-1:0] v, input logic [NCH-1:0] ok, input logic [NCH-1:0] m,
                               input bit on, input bit off, input bit c, input bit r);
    exp_t e;
    check_valid = v;
    check_ok    = ok;
    ch_en_mask  = m;
    assert_on   = on;
    assert_off  = off;
    clr         = c;
    rst         = r;
    modelStep(v, ok, m, on, off, c, r, e);
    expq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare the DUT against the oldest prediction just after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checkOutput("armed", 64'(armed), 64'(e.armed));
      checkOutput("pass_cnt", 64'(pass_cnt), 64'(e.pass));
      checkOutput("fail_cnt", 64'(fail_cnt), 64'(e.fail));
      checkOutput("fail_sticky", 64'(fail_sticky), 64'(e.sticky));
      checkOutput("first_fail_valid", 64'(first_fail_valid), 64'(e.ffv));
      checkOutput("first_fail_ch", 64'(first_fail_ch), 64'(e.ffch));
      checkOutput("first_fail_ts", 64'(first_fail_ts), 64'(e.ffts));
    end
  end

  initial begin
    int drain;
    rst = 1'b1;
    check_valid = '0;
    check_ok = '0;
    ch_en_mask = '0;
    assert_on = 1'b0;
    assert_off = 1'b0;
    clr = 1'b0;
    @(posedge clk);
    #2;
    repeat (2) applyStimulus(4'h0, 4'h0, 4'hF, 0, 0, 0, 1);
    checkOutput("reset_fail_cnt", 64'(fail_cnt), 64'd0);
    checkOutput("reset_armed", 64'(armed), 64'd0);

    $display("[TB] holdoff window");
    repeat (12) applyStimulus(4'hF, 4'h0, 4'hF, 0, 0, 0, 0);
    checkOutput("holdoff_ff_ts", 64'(first_fail_ts), 64'd8);
    checkOutput("holdoff_ff_ch", 64'(first_fail_ch), 64'd0);
    checkOutput("holdoff_sticky", 64'(fail_sticky), 64'hF);
    checkOutput("holdoff_fail_cnt", 64'(fail_cnt), 64'h4444);

    $display("[TB] clear with simultaneous fail");
    applyStimulus(4'h1, 4'h0, 4'hF, 0, 0, 1, 0);
    checkOutput("clr_fail_cnt", 64'(fail_cnt), 64'd0);
    checkOutput("clr_ffv", 64'(first_fail_valid), 64'd0);

    $display("[TB] off/on window");
    applyStimulus(4'h0, 4'h0, 4'hF, 0, 1, 0, 0);
    repeat (50) applyStimulus(4'h4, 4'h0, 4'hF, 0, 0, 0, 0);
    checkOutput("off_fail_cnt2", 64'(fail_cnt[8 +: CW]), 64'd0);
    applyStimulus(4'h0, 4'h0, 4'hF, 1, 0, 0, 0);
    checkOutput("on_armed", 64'(armed), 64'd1);
    applyStimulus(4'h4, 4'h4, 4'hF, 0, 0, 0, 0);
    checkOutput("on_pass_cnt2", 64'(pass_cnt[8 +: CW]), PASS_EN ? 64'd1 : 64'd0);

    $display("[TB] simultaneous on/off");
    applyStimulus(4'h0, 4'h0, 4'hF, 1, 1, 0, 0);
    checkOutput("onoff_armed", 64'(armed), 64'd0);
    applyStimulus(4'h0, 4'h0, 4'hF, 1, 0, 0, 0);

    $display("[TB] mask and priority");
    applyStimulus(4'h0, 4'h0, 4'hF, 0, 0, 1, 0);
    applyStimulus(4'hB, 4'h0, 4'hA, 0, 0, 0, 0);
    checkOutput("mask_ff_ch", 64'(first_fail_ch), 64'd1);
    checkOutput("mask_sticky", 64'(fail_sticky), 64'hA);

    $display("[TB] saturation");
    applyStimulus(4'h0, 4'h0, 4'hF, 0, 0, 1, 0);
    repeat (20) applyStimulus(4'h1, 4'h0, 4'h1, 0, 0, 0, 0);
    checkOutput("sat_fail_cnt0", 64'(fail_cnt[0 +: CW]), 64'd15);
    applyStimulus(4'h1, 4'h0, 4'hF, 0, 0, 1, 0);
    checkOutput("sat_clr_fail_cnt", 64'(fail_cnt), 64'd0);
    checkOutput("sat_clr_sticky", 64'(fail_sticky), 64'd0);

    $display("[TB] passes on channel 1");
    repeat (10) applyStimulus(4'h2, 4'h2, 4'hF, 0, 0, 0, 0);
    checkOutput("pass10", 64'(pass_cnt), PASS_EN ? 64'h00A0 : 64'd0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      applyStimulus(4'($urandom), 4'($urandom), 4'($urandom_range(15, 0) | 4'($urandom)),
                    ($urandom_range(14, 0) == 0), ($urandom_range(19, 0) == 0),
                    ($urandom_range(39, 0) == 0), ($urandom_range(149, 0) == 0));
    end
    check_valid = '0;
    assert_on = 1'b0;
    assert_off = 1'b0;
    clr = 1'b0;
    rst = 1'b0;

    drain = 0;
    while (expq.size() > 0 && drain < 10) begin
      @(posedge clk);
      #2;
      drain++;
    end
    checkOutput("queue_drained", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
